// File: rtl/otter_bp_pkg.sv
// Shared definitions for the OTTER branch predictor: index-width helper,
// counter initial-value helpers and the default BTB entry layout.
package otter_bp_pkg;

    // Number of PC bits used to select a BTB entry.
    function automatic int bp_idxw(input int entries);
        return $clog2(entries);
    endfunction

    // Counter value given to a freshly allocated entry (weakly taken).
    function automatic int bp_ctr_weak_t(input int ctr_bits);
        return 1 << (ctr_bits - 1);
    endfunction

    // Counter value after reset (weakly not-taken).
    function automatic int bp_ctr_weak_nt(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

    // Default geometry of the predictor.
    localparam int BP_XLEN     = 32;
    localparam int BP_ENTRIES  = 16;
    localparam int BP_CTR_BITS = 2;
    localparam int BP_IDXW     = bp_idxw(BP_ENTRIES);
    localparam int BP_TAGW     = BP_XLEN - BP_IDXW - 2;

    localparam int CTR_WEAK_T  = bp_ctr_weak_t(BP_CTR_BITS);
    localparam int CTR_WEAK_NT = bp_ctr_weak_nt(BP_CTR_BITS);

    // BTB entry layout at the default geometry.
    typedef struct packed {
        logic                   valid;
        logic [BP_TAGW-1:0]     tag;
        logic [BP_XLEN-1:0]     target;
        logic [BP_CTR_BITS-1:0] ctr;
    } bp_entry_t;

endpackage

// File: rtl/otter_branch_predictor_sat_ctr.sv
// Saturating up/down counter next-state logic used on the BTB update path.
module bp_sat_ctr #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] i_ctr,
    input  logic                i_up,
    output logic [CTR_BITS-1:0] o_ctr
);

    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN = '0;
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

    // Step toward taken or not-taken, holding at either end of the range.
    always_comb begin
        o_ctr = i_ctr;
        if (i_up) begin
            if (i_ctr != CTR_MAX) begin
                o_ctr = i_ctr + CTR_ONE;
            end
        end else begin
            if (i_ctr != CTR_MIN) begin
                o_ctr = i_ctr - CTR_ONE;
            end
        end
    end

endmodule

// File: rtl/otter_branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Fetch looks up combinationally; execute writes the resolved outcome back
// and raises MISPREDICT/REDIRECT_PC for the hazard unit.
// Optional statistics counters are built when OTTER_BP_STATS_EN is defined;
// otherwise STAT_* read as zero and no counter flops exist.
module otter_branch_predictor
    import otter_bp_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [XLEN-1:0] LKP_PC,
    output logic            PRED_TAKEN,
    output logic [XLEN-1:0] PRED_TARGET,
    input  logic            UPD_VALID,
    input  logic [XLEN-1:0] UPD_PC,
    input  logic            UPD_TAKEN,
    input  logic [XLEN-1:0] UPD_TARGET,
    input  logic            UPD_PRED_TAKEN,
    input  logic [XLEN-1:0] UPD_PRED_TARGET,
    output logic            MISPREDICT,
    output logic [XLEN-1:0] REDIRECT_PC,
    output logic [31:0]     STAT_BRANCHES,
    output logic [31:0]     STAT_MISPREDICTS
);

    localparam int IDXW = bp_idxw(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;
    localparam logic [CTR_BITS-1:0] CTR_ALLOC = CTR_BITS'(bp_ctr_weak_t(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_RESET = CTR_BITS'(bp_ctr_weak_nt(CTR_BITS));

    typedef struct packed {
        logic                valid;
        logic [TAGW-1:0]     tag;
        logic [XLEN-1:0]     target;
        logic [CTR_BITS-1:0] ctr;
    } entry_t;

    entry_t              w_entry [ENTRIES];

    logic [IDXW-1:0]     w_lkp_idx;
    logic [TAGW-1:0]     w_lkp_tag;
    entry_t              w_lkp_entry;
    logic                w_lkp_hit;

    logic [IDXW-1:0]     w_upd_idx;
    logic [TAGW-1:0]     w_upd_tag;
    entry_t              w_upd_old;
    logic                w_upd_hit;
    logic                w_entry_we;
    logic [CTR_BITS-1:0] w_ctr_next;
    entry_t              w_entry_next;

    logic [XLEN-1:0]     w_pc_plus4;
    logic                w_target_wrong;
    logic                w_unused_pc_lsbs;

    // Byte offset within the instruction word plays no part in indexing.
    assign w_unused_pc_lsbs = ^{LKP_PC[1:0], UPD_PC[1:0]};

    // ------------------------------------------------------------------
    // Entry storage: flops rather than RAM, because lookup is zero-latency
    // and reset must invalidate every entry at once.
    // ------------------------------------------------------------------
    genvar gi;
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
        entry_t r_entry;

        // Hold one BTB entry; reset invalidates it and parks the counter weakly not-taken.
        always_ff @(posedge CLK) begin
            if (RST) begin
                r_entry.valid <= 1'b0;
                r_entry.ctr   <= CTR_RESET;
            end else if (w_entry_we && (w_upd_idx == IDXW'(gi))) begin
                r_entry <= w_entry_next;
            end
        end

        assign w_entry[gi] = r_entry;
    end

    // ------------------------------------------------------------------
    // Fetch-side lookup. Reads current state, so a same-cycle update at the
    // same index is only seen on the following cycle.
    // ------------------------------------------------------------------
    assign w_lkp_idx   = LKP_PC[IDXW+1:2];
    assign w_lkp_tag   = LKP_PC[XLEN-1:IDXW+2];
    assign w_lkp_entry = w_entry[w_lkp_idx];
    assign w_lkp_hit   = w_lkp_entry.valid && (w_lkp_entry.tag == w_lkp_tag);

    assign PRED_TAKEN  = w_lkp_hit && w_lkp_entry.ctr[CTR_BITS-1];
    assign PRED_TARGET = PRED_TAKEN ? w_lkp_entry.target : '0;

    // ------------------------------------------------------------------
    // Execute-side update.
    // A miss that was not taken leaves the table alone; a taken miss
    // allocates, evicting whatever alias occupied the slot.
    // ------------------------------------------------------------------
    assign w_upd_idx  = UPD_PC[IDXW+1:2];
    assign w_upd_tag  = UPD_PC[XLEN-1:IDXW+2];
    assign w_upd_old  = w_entry[w_upd_idx];
    assign w_upd_hit  = w_upd_old.valid && (w_upd_old.tag == w_upd_tag);
    assign w_entry_we = UPD_VALID && (w_upd_hit || UPD_TAKEN);

    bp_sat_ctr #(
        .CTR_BITS (CTR_BITS)
    ) u_sat_ctr (
        .i_ctr (w_upd_old.ctr),
        .i_up  (UPD_TAKEN),
        .o_ctr (w_ctr_next)
    );

    // Build the replacement entry: train the counter on a hit, allocate on a miss.
    always_comb begin
        w_entry_next = w_upd_old;
        if (w_upd_hit) begin
            w_entry_next.ctr = w_ctr_next;
            if (UPD_TAKEN) begin
                w_entry_next.target = UPD_TARGET;
            end
        end else begin
            w_entry_next.valid  = 1'b1;
            w_entry_next.tag    = w_upd_tag;
            w_entry_next.target = UPD_TARGET;
            w_entry_next.ctr    = CTR_ALLOC;
        end
    end

    // ------------------------------------------------------------------
    // Misprediction detection and redirect. Purely a function of the
    // update inputs; the caller keeps UPD_VALID low while in reset.
    // ------------------------------------------------------------------
    assign w_pc_plus4     = UPD_PC + XLEN'(4);
    assign w_target_wrong = UPD_TAKEN && (UPD_TARGET != UPD_PRED_TARGET);
    assign MISPREDICT     = UPD_VALID && ((UPD_TAKEN != UPD_PRED_TAKEN) || w_target_wrong);
    assign REDIRECT_PC    = !MISPREDICT ? '0 :
                            (UPD_TAKEN ? UPD_TARGET : w_pc_plus4);

`ifdef OTTER_BP_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    // Count resolved branches and mispredictions, saturating at all-ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (UPD_VALID && (r_stat_branches != 32'hFFFF_FFFF)) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (MISPREDICT && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign STAT_BRANCHES    = r_stat_branches;
    assign STAT_MISPREDICTS = r_stat_mispredicts;
`else
    assign STAT_BRANCHES    = '0;
    assign STAT_MISPREDICTS = '0;
`endif

endmodule

// File: tb/tb_otter_branch_predictor.sv
// Directed scoreboard bench for otter_branch_predictor. Each stimulus cycle
// pushes the hand-computed expected outputs; a monitor on the falling edge
// pops and compares them against the DUT.
module tb_otter_branch_predictor;

    logic        CLK;
    logic        RST;
    logic [31:0] LKP_PC;
    logic        PRED_TAKEN;
    logic [31:0] PRED_TARGET;
    logic        UPD_VALID;
    logic [31:0] UPD_PC;
    logic        UPD_TAKEN;
    logic [31:0] UPD_TARGET;
    logic        UPD_PRED_TAKEN;
    logic [31:0] UPD_PRED_TARGET;
    logic        MISPREDICT;
    logic [31:0] REDIRECT_PC;
    logic [31:0] STAT_BRANCHES;
    logic [31:0] STAT_MISPREDICTS;

    otter_branch_predictor #(
        .XLEN     (32),
        .ENTRIES  (16),
        .CTR_BITS (2)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .LKP_PC           (LKP_PC),
        .PRED_TAKEN       (PRED_TAKEN),
        .PRED_TARGET      (PRED_TARGET),
        .UPD_VALID        (UPD_VALID),
        .UPD_PC           (UPD_PC),
        .UPD_TAKEN        (UPD_TAKEN),
        .UPD_TARGET       (UPD_TARGET),
        .UPD_PRED_TAKEN   (UPD_PRED_TAKEN),
        .UPD_PRED_TARGET  (UPD_PRED_TARGET),
        .MISPREDICT       (MISPREDICT),
        .REDIRECT_PC      (REDIRECT_PC),
        .STAT_BRANCHES    (STAT_BRANCHES),
        .STAT_MISPREDICTS (STAT_MISPREDICTS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       nm;
        logic        pt;
        logic [31:0] ptgt;
        logic        mp;
        logic [31:0] rd;
        logic [31:0] sbr;
        logic [31:0] smp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Expected statistics, advanced by the stimulus as updates are applied.
    int unsigned exp_br = 0;
    int unsigned exp_mp = 0;

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s.%s: got %08h expected %08h", nm, fld, act, exp_v);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            $display("txn %-16s pt=%0d tgt=%08h mp=%0d rd=%08h br=%0d mpc=%0d",
                     e.nm, PRED_TAKEN, PRED_TARGET, MISPREDICT, REDIRECT_PC,
                     STAT_BRANCHES, STAT_MISPREDICTS);
            chk(e.nm, "pred_taken",  {31'd0, PRED_TAKEN}, {31'd0, e.pt});
            chk(e.nm, "pred_target", PRED_TARGET, e.ptgt);
            chk(e.nm, "mispredict",  {31'd0, MISPREDICT}, {31'd0, e.mp});
            chk(e.nm, "redirect",    REDIRECT_PC, e.rd);
            chk(e.nm, "stat_br",     STAT_BRANCHES, e.sbr);
            chk(e.nm, "stat_mp",     STAT_MISPREDICTS, e.smp);
        end
    end

    // Drive one cycle of stimulus and queue its expected outputs.
    task automatic step(input string nm, input logic rst, input logic [31:0] lpc,
                        input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt,
                        input logic e_pt, input logic [31:0] e_ptgt,
                        input logic e_mp, input logic [31:0] e_rd);
        exp_t e;
        RST             = rst;
        LKP_PC          = lpc;
        UPD_VALID       = uv;
        UPD_PC          = upc;
        UPD_TAKEN       = ut;
        UPD_TARGET      = utgt;
        UPD_PRED_TAKEN  = upt;
        UPD_PRED_TARGET = uptgt;
        e.nm   = nm;
        e.pt   = e_pt;
        e.ptgt = e_ptgt;
        e.mp   = e_mp;
        e.rd   = e_rd;
`ifdef OTTER_BP_STATS_EN
        e.sbr  = exp_br;
        e.smp  = exp_mp;
`else
        e.sbr  = 32'd0;
        e.smp  = 32'd0;
`endif
        q.push_back(e);
        if (rst) begin
            exp_br = 0;
            exp_mp = 0;
        end else if (uv) begin
            exp_br++;
            if (e_mp) exp_mp++;
        end
        @(posedge CLK);
        #1;
    endtask

    // Lookup-only cycle with no update.
    task automatic look(input string nm, input logic [31:0] lpc,
                        input logic e_pt, input logic [31:0] e_ptgt);
        step(nm, 1'b0, lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
             e_pt, e_ptgt, 1'b0, 32'h0);
    endtask

    initial begin
        RST = 1'b1; LKP_PC = '0; UPD_VALID = 1'b0; UPD_PC = '0; UPD_TAKEN = 1'b0;
        UPD_TARGET = '0; UPD_PRED_TAKEN = 1'b0; UPD_PRED_TARGET = '0;
        repeat (2) @(posedge CLK);
        #1;

        //    name             rst   lkp_pc        uv  upc           ut  utgt          upt pred_tgt      e_pt e_ptgt      e_mp e_rd
        look("rst_lookup",           32'h40,                                                             0, 32'h0);
        step("alloc",          0,    32'h40,       1,  32'h40,       1,  32'h100,      0,  32'h0,        0, 32'h0,        1, 32'h100);
        look("hit_after_alloc",      32'h40,                                                             1, 32'h100);
        step("nt_first",       0,    32'h40,       1,  32'h40,       0,  32'h100,      1,  32'h100,      1, 32'h100,      1, 32'h44);
        step("nt_second",      0,    32'h40,       1,  32'h40,       0,  32'h0,        0,  32'h0,        0, 32'h0,        0, 32'h0);
        step("nt_sat_low",     0,    32'h40,       1,  32'h40,       0,  32'h0,        0,  32'h0,        0, 32'h0,        0, 32'h0);
        step("t_from_zero",    0,    32'h40,       1,  32'h40,       1,  32'h100,      0,  32'h0,        0, 32'h0,        1, 32'h100);
        step("t_new_target",   0,    32'h40,       1,  32'h40,       1,  32'h104,      0,  32'h0,        0, 32'h0,        1, 32'h104);
        look("target_updated",       32'h40,                                                             1, 32'h104);
        step("t_to_strong",    0,    32'h40,       1,  32'h40,       1,  32'h104,      1,  32'h104,      1, 32'h104,      0, 32'h0);
        step("t_sat_high",     0,    32'h40,       1,  32'h40,       1,  32'h104,      1,  32'h104,      1, 32'h104,      0, 32'h0);
        step("nt_from_strong", 0,    32'h40,       1,  32'h40,       0,  32'h0,        1,  32'h104,      1, 32'h104,      1, 32'h44);
        look("still_taken",          32'h40,                                                             1, 32'h104);
        step("wrong_target",   0,    32'h40,       1,  32'h40,       1,  32'h108,      1,  32'h104,      1, 32'h104,      1, 32'h108);
        step("alias_alloc",    0,    32'h40,       1,  32'h80,       1,  32'h200,      0,  32'h0,        1, 32'h108,      1, 32'h200);
        look("alias_evicted",        32'h40,                                                             0, 32'h0);
        look("alias_hit",            32'h80,                                                             1, 32'h200);
        step("miss_nt_noop",   0,    32'h80,       1,  32'hC0,       0,  32'h0,        0,  32'h0,        1, 32'h200,      0, 32'h0);
        look("after_noop",           32'h80,                                                             1, 32'h200);
        step("pc_wrap_lsb",    0,    32'h82,       1,  32'hFFFF_FFFC,0,  32'h0,        1,  32'h0,        1, 32'h200,      1, 32'h0);
        look("wrap_no_alloc",        32'hFFFF_FFFC,                                                      0, 32'h0);
        step("same_cycle",     0,    32'h40,       1,  32'h40,       1,  32'h300,      0,  32'h0,        0, 32'h0,        1, 32'h300);
        look("same_cycle_next",      32'h40,                                                             1, 32'h300);
        step("upd_in_reset",   1,    32'h44,       1,  32'h44,       1,  32'h400,      0,  32'h0,        0, 32'h0,        1, 32'h400);
        look("reset_discard",        32'h44,                                                             0, 32'h0);
        look("reset_cleared",        32'h40,                                                             0, 32'h0);
        step("st_alloc",       0,    32'h48,       1,  32'h48,       1,  32'h500,      0,  32'h0,        0, 32'h0,        1, 32'h500);
        step("st_hit_t",       0,    32'h48,       1,  32'h48,       1,  32'h500,      1,  32'h500,      1, 32'h500,      0, 32'h0);
        step("st_hit_nt",      0,    32'h48,       1,  32'h48,       0,  32'h0,        1,  32'h500,      1, 32'h500,      1, 32'h4C);
        step("st_hit_t2",      0,    32'h48,       1,  32'h48,       1,  32'h500,      1,  32'h500,      1, 32'h500,      0, 32'h0);
        step("st_miss_nt",     0,    32'h48,       1,  32'h4C,       0,  32'h0,        0,  32'h0,        1, 32'h500,      0, 32'h0);
        look("st_final",             32'h48,                                                             1, 32'h500);

        // Every queued expectation must have been consumed by the monitor.
        @(negedge CLK);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
